gate_unit_arbiter: RTL and testbench

- Shares one bitwise 2-input logic unit (AND/OR/XOR/NAND/NOR/XNOR/NOT/pass) among NREQ requesters.
- Arbitration is round-robin, with valid/ready handshakes on both request and response sides.
- The result is registered and held until the consumer accepts it.
- Sits between the requesting sequencers and the shared gate datapath; it is the only block that drives that datapath.

---
 rtl/gate_unit_arbiter.sv | 127 ++++++++++++
 tb/tb_gate_unit_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise 2-input gate unit among NREQ requesters.
// The result is registered and held until the consumer takes it.
module gate_unit_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int CW   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*W-1:0]         req_a,
   input  logic [NREQ*W-1:0]         req_b,
   input  logic [NREQ*3-1:0]         req_op,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [W-1:0]              rsp_data,
   output logic [CW-1:0]             grant_cnt
);
   localparam int IW = $clog2(NREQ);

   generate
      if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
         $error("gate_unit_arbiter: NREQ must be in 2..8");
      end
   endgenerate

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t          r_state, w_state_nxt;
   logic [IW-1:0]   r_ptr, r_id, w_gnt, w_ptr_nxt;
   logic [W-1:0]    r_data, w_a, w_b, w_res;
   logic [2:0]      w_op;
   logic [CW-1:0]   r_cnt;
   logic            w_found, w_can_accept, w_accept;
   logic [W-1:0]    w_av [NREQ];
   logic [W-1:0]    w_bv [NREQ];
   logic [2:0]      w_opv [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign w_av[i]  = req_a[i*W +: W];
      assign w_bv[i]  = req_b[i*W +: W];
      assign w_opv[i] = req_op[i*3 +: 3];
   end

   // Rotate the search origin to r_ptr; the sum wraps once at most since both terms are < NREQ.
   always_comb begin
      logic [IW:0]   sum;
      logic [IW-1:0] idx;
      w_found = 1'b0;
      w_gnt   = '0;
      sum     = '0;
      idx     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         sum = {1'b0, r_ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
         idx = sum[IW-1:0];
         if (!w_found && req_valid[idx]) begin
            w_found = 1'b1;
            w_gnt   = idx;
         end
      end
   end

   assign w_a  = w_av[w_gnt];
   assign w_b  = w_bv[w_gnt];
   assign w_op = w_opv[w_gnt];

   always_comb begin
      w_res = '0;
      case (w_op)
         3'd0: w_res = w_a & w_b;
         3'd1: w_res = w_a | w_b;
         3'd2: w_res = w_a ^ w_b;
         3'd3: w_res = ~(w_a & w_b);
         3'd4: w_res = ~(w_a | w_b);
         3'd5: w_res = ~(w_a ^ w_b);
         3'd6: w_res = ~w_a;
         3'd7: w_res = w_b;
         default: w_res = '0;
      endcase
   end

   assign w_can_accept = (r_state == S_EMPTY) | rsp_ready;
   assign w_accept     = rst_n & w_found & w_can_accept;
   assign w_ptr_nxt    = (w_gnt == IW'(NREQ-1)) ? '0 : w_gnt + 1'b1;

   always_comb begin
      req_ready = '0;
      if (w_accept) req_ready[w_gnt] = 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
         S_FULL:  if (w_accept) w_state_nxt = S_FULL;
                  else if (rsp_ready) w_state_nxt = S_EMPTY;
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
         r_ptr   <= '0;
         r_id    <= '0;
         r_data  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_data <= w_res;
            r_id   <= w_gnt;
            r_ptr  <= w_ptr_nxt;
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign rsp_valid = (r_state == S_FULL);
   assign rsp_id    = r_id;
   assign rsp_data  = r_data;
   assign grant_cnt = r_cnt;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench for gate_unit_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_gate_unit_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int CW   = 12;
   localparam int IW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic                 clk;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*W-1:0]    req_a;
   logic [NREQ*W-1:0]    req_b;
   logic [NREQ*3-1:0]    req_op;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IW-1:0]        rsp_id;
   logic [W-1:0]         rsp_data;
   logic [CW-1:0]        grant_cnt;

   gate_unit_arbiter #(.NREQ(NREQ), .W(W), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .grant_cnt(grant_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: architectural state of the arbiter
   int            m_ptr, m_id, m_cnt;
   bit            m_valid;
   logic [W-1:0]  m_data;

   function automatic int find_winner(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++)
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [W-1:0] gate_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~(a & b);
         3'd4: return ~(a | b);
         3'd5: return ~(a ^ b);
         3'd6: return ~a;
         default: return b;
      endcase
   endfunction

   function automatic logic [NREQ-1:0] exp_ready();
      int g;
      g = find_winner(req_valid, m_ptr);
      if (rst_n && g >= 0 && (!m_valid || rsp_ready)) return NREQ'(1) << g;
      return '0;
   endfunction

   function automatic void model_reset();
      m_ptr = 0; m_id = 0; m_cnt = 0; m_valid = 0; m_data = '0;
   endfunction

   task automatic tick();
      int g;
      bit acc;
      logic [W-1:0] a, b;
      logic [2:0] op;
      g   = find_winner(req_valid, m_ptr);
      acc = rst_n && g >= 0 && (!m_valid || rsp_ready);
      if (g >= 0) begin
         a  = req_a[g*W +: W];
         b  = req_b[g*W +: W];
         op = req_op[g*3 +: 3];
      end else begin
         a = '0; b = '0; op = '0;
      end
      @(posedge clk);
      if (acc) begin
         m_data  = gate_op(a, b, op);
         m_id    = g;
         m_valid = 1;
         m_ptr   = (g + 1) % NREQ;
         if (m_cnt < CMAX) m_cnt++;
      end else if (m_valid && rsp_ready) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0;
      req_a = $urandom; req_b = $urandom; req_op = NREQ*3'($urandom);
      model_reset();
      #12;
      n_checks++;
      if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_data, grant_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b id=%0d data=%h cnt=%0d want all 0", rsp_valid, rsp_id, rsp_data, grant_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1; rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== m_data) begin
         n_fail++;
         $display("FAIL reset_first_rsp: valid=%b id=%0d data=%h want 1/0/%h", rsp_valid, rsp_id, rsp_data, m_data);
      end
   endtask

   task automatic test_opcodes();
      logic [W-1:0] tbl [8];
      tbl = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C, 8'hA5};
      rsp_ready = 1'b1;
      req_valid = 4'b0100;
      req_a[2*W +: W] = 8'hC3;
      req_b[2*W +: W] = 8'hA5;
      for (int unsigned op = 0; op < 8; op++) begin
         req_op[2*3 +: 3] = 3'(op);
         #1;
         n_checks++;
         if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL op_ready[%0d]: got %b want 0100", op, req_ready); end
         tick();
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== tbl[op] || rsp_data !== m_data) begin
            n_fail++;
            $display("FAIL op_result[%0d]: valid=%b id=%0d data=%h want 1/2/%h", op, rsp_valid, rsp_id, rsp_data, tbl[op]);
         end
      end
      req_valid = '0;
      tick();
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL op_drain: valid=%b want 0", rsp_valid); end
   endtask

   task automatic test_round_robin();
      apply_reset();
      req_valid = '1; rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_a = $urandom; req_b = $urandom; req_op = NREQ*3'($urandom);
         tick();
         n_checks++;
         if (rsp_id !== IW'(i % NREQ) || rsp_data !== m_data || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_seq[%0d]: id=%0d data=%h want %0d/%h", i, rsp_id, rsp_data, i % NREQ, m_data);
         end
      end
      n_checks++;
      if (grant_cnt !== CW'(8)) begin n_fail++; $display("FAIL rr_count: got %0d want 8", grant_cnt); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] held;
      apply_reset();
      rsp_ready = 1'b0; req_valid = 4'b0010;
      req_a = $urandom; req_b = $urandom; req_op = NREQ*3'($urandom);
      tick();
      held = m_data;
      req_valid = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if (req_ready !== '0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, req_ready); end
         tick();
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== held) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: valid=%b id=%0d data=%h want 1/1/%h", i, rsp_valid, rsp_id, rsp_data, held);
         end
      end
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1000", req_ready); end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== m_data) begin
         n_fail++;
         $display("FAIL bp_no_bubble: valid=%b id=%0d data=%h want 1/3/%h", rsp_valid, rsp_id, rsp_data, m_data);
      end
   endtask

   task automatic test_skip_wrap();
      int exp_ids [4] = '{1, 2, 3, 1};
      logic [NREQ-1:0] vals [4] = '{4'b0110, 4'b0110, 4'b1110, 4'b1110};
      apply_reset();
      rsp_ready = 1'b1; req_valid = 4'b0100;
      tick();
      for (int i = 0; i < 4; i++) begin
         req_valid = vals[i];
         req_a = $urandom; req_b = $urandom; req_op = NREQ*3'($urandom);
         #1;
         n_checks++;
         if (req_ready !== NREQ'(1) << exp_ids[i]) begin
            n_fail++; $display("FAIL skip_ready[%0d]: got %b want bit %0d", i, req_ready, exp_ids[i]);
         end
         tick();
         n_checks++;
         if (rsp_id !== IW'(exp_ids[i]) || rsp_data !== m_data) begin
            n_fail++; $display("FAIL skip_id[%0d]: id=%0d data=%h want %0d/%h", i, rsp_id, rsp_data, exp_ids[i], m_data);
         end
      end
   endtask

   task automatic test_reset_midop();
      apply_reset();
      rsp_ready = 1'b0; req_valid = 4'b0100;
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL midop_loaded: valid=%b want 1", rsp_valid); end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== '0) begin
         n_fail++; $display("FAIL midop_async: valid=%b ready=%b want 0/0000", rsp_valid, req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1; req_valid = '1; rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midop_ptr: ready=%b want 0001", req_ready); end
   endtask

   task automatic test_saturation();
      apply_reset();
      req_valid = '1; rsp_ready = 1'b1;
      for (int i = 0; i < CMAX - 1; i++) tick();
      n_checks++;
      if (grant_cnt !== CW'(CMAX - 1)) begin n_fail++; $display("FAIL sat_pre: got %0d want %0d", grant_cnt, CMAX - 1); end
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (grant_cnt !== CW'(CMAX) || grant_cnt !== CW'(m_cnt)) begin
         n_fail++; $display("FAIL sat_hold: got %0d want %0d", grant_cnt, CMAX);
      end
   endtask

   task automatic test_random();
      logic [NREQ-1:0] er;
      for (int i = 0; i < 300; i++) begin
         req_valid = NREQ'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         req_a = $urandom; req_b = $urandom; req_op = NREQ*3'($urandom);
         #1;
         er = exp_ready();
         n_checks++;
         if (req_ready !== er) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, req_ready, er); end
         tick();
         n_checks++;
         if ({rsp_valid, rsp_id, rsp_data, grant_cnt} !== {m_valid, IW'(m_id), m_data, CW'(m_cnt)}) begin
            n_fail++;
            $display("FAIL rand_rsp[%0d]: v=%b id=%0d d=%h c=%0d want %b/%0d/%h/%0d",
                     i, rsp_valid, rsp_id, rsp_data, grant_cnt, m_valid, m_id, m_data, m_cnt);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_op = '0;
      test_reset();
      test_opcodes();
      test_round_robin();
      test_backpressure();
      test_skip_wrap();
      test_reset_midop();
      apply_reset();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
